// File: rtl/vec_ctrl_seq_if.sv
// rtl/vec_ctrl_seq_if.sv - job, OBuf, mv/ve/ev sync bundle for the vector-stage controller (VCTRL_PERF_EN adds perf counters)
interface vec_ctrl_seq_if #(
    parameter int OBUF_COL = 64,
    parameter int VE_DEPTH = 4
);
    localparam int AW = $clog2(OBUF_COL);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(VE_DEPTH) + 1;

    logic          start;
    logic [CW-1:0] colCnt;
    logic          busy;
    logic          done;
    logic          mvEmpty;
    logic          mvRSync;
    logic          obufRdEn;
    logic [AW-1:0] obufRdAddr;
    logic          obufRdVld;
    logic          veWSync;
    logic          evEmpty;
    logic          evRSync;
    logic [OW-1:0] outstanding;
`ifdef VCTRL_PERF_EN
    logic [31:0]   perfMvStall;
    logic [31:0]   perfVeStall;
`endif

    // Environment side: sync block, OBuf and job issuer
    modport master (
        output start, colCnt, mvEmpty, obufRdVld, evEmpty,
`ifdef VCTRL_PERF_EN
        input  perfMvStall, perfVeStall,
`endif
        input  busy, done, mvRSync, obufRdEn, obufRdAddr, veWSync, evRSync, outstanding
    );

    // Controller side
    modport slave (
        input  start, colCnt, mvEmpty, obufRdVld, evEmpty,
`ifdef VCTRL_PERF_EN
        output perfMvStall, perfVeStall,
`endif
        output busy, done, mvRSync, obufRdEn, obufRdAddr, veWSync, evRSync, outstanding
    );
endinterface

// File: rtl/vec_ctrl_seq.sv
// rtl/vec_ctrl_seq.sv - vector-stage column sequencer between mv queue, OBuf and VE (VCTRL_PERF_EN adds stall counters)
module vec_ctrl_seq #(
    parameter int OBUF_COL = 64,
    parameter int VE_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    vec_ctrl_seq_if.slave bus
);
    localparam int AW = $clog2(OBUF_COL);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(VE_DEPTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_MV = 3'd1,
        S_RD      = 3'd2,
        S_ISSUE   = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] col_cnt_q, col_cnt_d;
    logic [CW-1:0] issued_q, issued_d;
    logic [CW-1:0] retired_q, retired_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic          zero_done_q, zero_done_d;

    logic          job_start;
    logic          zero_start;
    logic          mv_take;
    logic          ve_room;
    logic          ve_issue;
    logic          last_col;
    logic          retire;
    logic          drain_done;

    // Shared decode used by both the next-state and output logic
    always_comb begin
        job_start  = (state_q == S_IDLE) && bus.start && (bus.colCnt != '0);
        zero_start = (state_q == S_IDLE) && bus.start && (bus.colCnt == '0);
        mv_take    = (state_q == S_WAIT_MV) && !bus.mvEmpty;
        ve_room    = outstanding_q < OW'(VE_DEPTH);
        ve_issue   = (state_q == S_ISSUE) && ve_room;
        last_col   = (issued_q + CW'(1)) == col_cnt_q;
        retire     = !bus.evEmpty && (outstanding_q != '0);
        drain_done = (state_q == S_DRAIN) && (retired_q == col_cnt_q);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one column walks WAIT_MV -> RD -> ISSUE, the last one parks in DRAIN
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (job_start)        state_d = S_WAIT_MV;
            S_WAIT_MV: if (!bus.mvEmpty)     state_d = S_RD;
            S_RD:      if (bus.obufRdVld)    state_d = S_ISSUE;
            S_ISSUE:   if (ve_room)          state_d = last_col ? S_DRAIN : S_WAIT_MV;
            S_DRAIN:   if (drain_done)       state_d = S_IDLE;
            default:                         state_d = S_IDLE;
        endcase
    end

    // Outputs: sync pulses are combinational so the sync block sees them in the deciding cycle
    always_comb begin
        bus.busy        = (state_q != S_IDLE);
        bus.done        = drain_done || zero_done_q;
        bus.mvRSync     = mv_take;
        bus.obufRdEn    = mv_take;
        bus.obufRdAddr  = mv_take ? rd_ptr_q : '0;
        bus.veWSync     = ve_issue;
        bus.evRSync     = retire;
        bus.outstanding = outstanding_q;
    end

    // Job bookkeeping next-state; rdPtr deliberately survives across jobs to mirror the sync block's mv pointer
    always_comb begin
        rd_ptr_d      = rd_ptr_q;
        col_cnt_d     = col_cnt_q;
        issued_d      = issued_q;
        retired_d     = retired_q;
        outstanding_d = outstanding_q;
        zero_done_d   = zero_start;

        if (mv_take) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (job_start) begin
            col_cnt_d = bus.colCnt;
            issued_d  = '0;
        end else if (ve_issue) begin
            issued_d  = issued_q + CW'(1);
        end

        if (job_start) begin
            retired_d = '0;
        end else if (retire) begin
            retired_d = retired_q + CW'(1);
        end

        if (ve_issue && !retire) begin
            outstanding_d = outstanding_q + OW'(1);
        end else if (!ve_issue && retire) begin
            outstanding_d = outstanding_q - OW'(1);
        end
    end

    // Job bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q      <= '0;
            col_cnt_q     <= '0;
            issued_q      <= '0;
            retired_q     <= '0;
            outstanding_q <= '0;
            zero_done_q   <= 1'b0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            col_cnt_q     <= col_cnt_d;
            issued_q      <= issued_d;
            retired_q     <= retired_d;
            outstanding_q <= outstanding_d;
            zero_done_q   <= zero_done_d;
        end
    end

`ifdef VCTRL_PERF_EN
    logic [31:0] perf_mv_q, perf_mv_d;
    logic [31:0] perf_ve_q, perf_ve_d;

    // Saturating stall counters, cleared when a non-empty job is accepted
    always_comb begin
        perf_mv_d = perf_mv_q;
        perf_ve_d = perf_ve_q;
        if (job_start) begin
            perf_mv_d = '0;
            perf_ve_d = '0;
        end else begin
            if ((state_q == S_WAIT_MV) && bus.mvEmpty && (perf_mv_q != '1)) begin
                perf_mv_d = perf_mv_q + 32'd1;
            end
            if ((state_q == S_ISSUE) && (outstanding_q == OW'(VE_DEPTH)) && (perf_ve_q != '1)) begin
                perf_ve_d = perf_ve_q + 32'd1;
            end
        end
    end

    // Stall counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_mv_q <= '0;
            perf_ve_q <= '0;
        end else begin
            perf_mv_q <= perf_mv_d;
            perf_ve_q <= perf_ve_d;
        end
    end

    // Stall counter outputs
    always_comb begin
        bus.perfMvStall = perf_mv_q;
        bus.perfVeStall = perf_ve_q;
    end
`endif
endmodule
